// File: rtl/ones_count_arbiter_pkg.sv
// Shared types and width helpers for the round-robin ones-count arbiter.
// Optional early-exit scan is enabled with ONES_COUNT_ARB_EARLY_EXIT_EN.
package ones_count_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCount,
    StDone
  } state_e;

  localparam int unsigned DefaultWidth     = 30;
  localparam int unsigned DefaultRequesters = 4;

  // Wide enough to hold 0..w inclusive.
  function automatic int unsigned count_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ones_count_arbiter_popcount_engine.sv
// Serial popcount datapath: shift register, bit counter, ones counter and done flag.
// ONES_COUNT_ARB_EARLY_EXIT_EN ends the scan once no set bits remain.
module popcount_engine
  import ones_count_arbiter_pkg::*;
#(
  parameter int unsigned W  = DefaultWidth,
  parameter int unsigned CW = count_width(W)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          load_i,
  input  logic          shift_i,
  input  logic [W-1:0]  data_i,
  output logic [CW-1:0] ones_o,
  output logic          done_o
);

  logic [W-1:0]  sreg_q, sreg_d;
  logic [CW-1:0] bits_q, bits_d;
  logic [CW-1:0] ones_q, ones_d;
  logic          last_bit;
  logic          empty_next;

  always_comb begin
    sreg_d = sreg_q;
    bits_d = bits_q;
    ones_d = ones_q;
    if (load_i) begin
      sreg_d = data_i;
      bits_d = '0;
      ones_d = '0;
    end else if (shift_i) begin
      sreg_d = sreg_q >> 1;
      bits_d = bits_q + CW'(1);
      ones_d = ones_q + CW'(sreg_q[0]);
    end
  end

  assign last_bit = (bits_q == CW'(W - 1));

`ifdef ONES_COUNT_ARB_EARLY_EXIT_EN
  // This shift leaves the register empty, so every remaining bit is zero.
  assign empty_next = (sreg_q[W-1:1] == '0);
`else
  assign empty_next = 1'b0;
`endif

  assign done_o = shift_i & (last_bit | empty_next);
  assign ones_o = ones_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sreg_q <= '0;
      bits_q <= '0;
      ones_q <= '0;
    end else begin
      sreg_q <= sreg_d;
      bits_q <= bits_d;
      ones_q <= ones_d;
    end
  end

endmodule

// File: rtl/ones_count_arbiter.sv
// Round-robin arbiter that grants one requester at a time and returns the ones count of its word.
// ONES_COUNT_ARB_EARLY_EXIT_EN (in popcount_engine) shortens the scan for words with high zeros.
module ones_count_arbiter
  import ones_count_arbiter_pkg::*;
#(
  parameter  int unsigned W  = DefaultWidth,
  parameter  int unsigned N  = DefaultRequesters,
  localparam int unsigned CW = count_width(W),
  localparam int unsigned IW = id_width(N)
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] data,
  output logic [N-1:0]   gnt,
  output logic           busy,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [IW-1:0]  res_id,
  output logic [CW-1:0]  res_count
);

  state_e        state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] id_q, id_d;
  logic          armed_q;

  logic          pick_found;
  logic [IW-1:0] pick_idx;
  logic [IW-1:0] scan_idx;
  logic [W-1:0]  word_sel;
  logic          eng_load;
  logic          eng_shift;
  logic          eng_done;
  logic [CW-1:0] eng_ones;

  // First pending requester at or after the pointer, wrapping past N-1.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    scan_idx   = '0;
    for (int k = 0; k < N; k++) begin
      scan_idx = IW'((int'(ptr_q) + k) % N);
      if (!pick_found && req[scan_idx]) begin
        pick_found = 1'b1;
        pick_idx   = scan_idx;
      end
    end
  end

  assign word_sel = data[int'(pick_idx)*W +: W];

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    gnt       = '0;
    eng_load  = 1'b0;
    eng_shift = 1'b0;
    unique case (state_q)
      StIdle: begin
        // armed_q keeps the first cycle after reset release grant-free.
        if (armed_q && pick_found) begin
          gnt[pick_idx] = 1'b1;
          eng_load      = 1'b1;
          id_d          = pick_idx;
          state_d       = StCount;
        end
      end
      StCount: begin
        eng_shift = 1'b1;
        if (eng_done) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (res_ready) begin
          ptr_d   = (id_q == IW'(N - 1)) ? '0 : id_q + IW'(1);
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      id_q    <= '0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      armed_q <= 1'b1;
    end
  end

  popcount_engine #(
    .W  (W),
    .CW (CW)
  ) u_engine (
    .clock   (clock),
    .reset   (reset),
    .load_i  (eng_load),
    .shift_i (eng_shift),
    .data_i  (word_sel),
    .ones_o  (eng_ones),
    .done_o  (eng_done)
  );

  assign busy      = (state_q != StIdle);
  assign res_valid = (state_q == StDone);
  assign res_id    = id_q;
  assign res_count = eng_ones;

endmodule

// File: tb/tb_ones_count_arbiter.sv
// Self-checking bench for ones_count_arbiter: directed table, reset/fairness sequence, random traffic.
module tb_ones_count_arbiter;

  localparam int unsigned W  = 30;
  localparam int unsigned N  = 4;
  localparam int unsigned CW = $clog2(W + 1);
  localparam int unsigned IW = $clog2(N);

  logic           clock = 1'b0;
  logic           reset;
  logic [N-1:0]   req;
  logic [N*W-1:0] data;
  logic [N-1:0]   gnt;
  logic           busy;
  logic           res_valid;
  logic           res_ready;
  logic [IW-1:0]  res_id;
  logic [CW-1:0]  res_count;

  int checks = 0;
  int errors = 0;
  int mptr   = 0;

  always #5 clock = ~clock;

  ones_count_arbiter #(
    .W (W),
    .N (N)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .data      (data),
    .gnt       (gnt),
    .busy      (busy),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_id    (res_id),
    .res_count (res_count)
  );

  typedef struct {
    logic [N-1:0] req;
    logic [W-1:0] word;
    int           rdelay;
    int           exp_id;
    int           exp_cnt;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Round-robin choice from the reference pointer.
  function automatic int model_pick(input logic [N-1:0] r);
    logic [N-1:0] sh;
    for (int k = 0; k < N; k++) begin
      sh = r >> ((mptr + k) % N);
      if (sh[0]) return (mptr + k) % N;
    end
    return -1;
  endfunction

  // Cycles from grant to first res_valid.
  function automatic int model_lat(input logic [W-1:0] word);
`ifdef ONES_COUNT_ARB_EARLY_EXIT_EN
    logic [W-1:0] t;
    int h;
    t = word;
    h = 0;
    while (t != '0) begin
      t = t >> 1;
      h++;
    end
    return ((h == 0) ? 1 : h) + 1;
`else
    return W + 1;
`endif
  endfunction

  function automatic logic [N*W-1:0] rand_data();
    logic [N*W-1:0] d;
    for (int s = 0; s < N; s++) d[s*W +: W] = W'($urandom);
    return d;
  endfunction

  // Called just after a posedge; returns just after the acceptance posedge.
  task automatic txn(input string tag, input logic [N-1:0] r, input logic [N*W-1:0] d,
                     input int rdelay, input int exp_id, input int exp_cnt);
    int           gi;
    int           wt;
    int           lat;
    logic [N-1:0] g;
    logic [N-1:0] eg;
    logic [W-1:0] word;
    bit           stray;
    bit           hold_bad;
    gi   = model_pick(r);
    word = d[gi*W +: W];
    eg   = N'(1) << gi;
    req       = r;
    data      = d;
    res_ready = 1'b0;
    wt = 0;
    @(negedge clock);
    while (gnt == '0 && wt < 40) begin
      @(negedge clock);
      wt++;
    end
    g = gnt;
    chk({tag, "_gnt"}, g, eg);
    chk({tag, "_idle_busy"}, busy, 0);
    if (g == '0) return;
    @(posedge clock); #1;
    req       = r & ~g;
    res_ready = (rdelay == 0);
    lat   = 0;
    stray = 1'b0;
    do begin
      @(negedge clock);
      lat++;
      if (lat == 1) chk({tag, "_busy"}, busy, 1);
      if (gnt != '0) stray = 1'b1;
    end while (!res_valid && lat < 100);
    chk({tag, "_latency"}, lat, model_lat(word));
    chk({tag, "_id"}, res_id, exp_id);
    chk({tag, "_count"}, res_count, exp_cnt);
    hold_bad = 1'b0;
    for (int j = 1; j <= rdelay; j++) begin
      @(posedge clock); #1;
      if (j == rdelay) res_ready = 1'b1;
      @(negedge clock);
      if (!res_valid || res_count != CW'(exp_cnt) || gnt != '0) hold_bad = 1'b1;
    end
    if (rdelay > 0) chk({tag, "_hold"}, hold_bad, 0);
    chk({tag, "_no_gnt_busy"}, stray, 0);
    @(posedge clock); #1;
    res_ready = 1'b0;
    mptr = (gi + 1) % N;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [N*W-1:0] d;
    logic [N-1:0]   r;
    int             gi;
    int             wt;

    vecs[0] = '{req: 4'b0100, word: 30'h3FFFFFFF, rdelay: 0, exp_id: 2, exp_cnt: 30};
    vecs[1] = '{req: 4'b0001, word: 30'h00000005, rdelay: 5, exp_id: 0, exp_cnt: 2};
    vecs[2] = '{req: 4'b1000, word: 30'h00000001, rdelay: 0, exp_id: 3, exp_cnt: 1};
    vecs[3] = '{req: 4'b0010, word: 30'h00000000, rdelay: 0, exp_id: 1, exp_cnt: 0};
    vecs[4] = '{req: 4'b0100, word: 30'h20000000, rdelay: 2, exp_id: 2, exp_cnt: 1};
    vecs[5] = '{req: 4'b0001, word: 30'h2AAAAAAA, rdelay: 1, exp_id: 0, exp_cnt: 15};

    reset     = 1'b1;
    req       = 4'b0100;
    data      = '0;
    res_ready = 1'b0;
    #2;
    chk("rst_gnt", gnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", res_valid, 0);
    chk("rst_id", res_id, 0);
    chk("rst_count", res_count, 0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;

    for (int i = 0; i < 6; i++) begin
      d = rand_data();
      d[vecs[i].exp_id*W +: W] = vecs[i].word;
      txn($sformatf("vec%0d", i), vecs[i].req, d, vecs[i].rdelay, vecs[i].exp_id,
          vecs[i].exp_cnt);
    end

    // Reset in the middle of a scan discards the word.
    d = rand_data();
    d[2*W +: W] = 30'h3FFFFFFF;
    req  = 4'b0100;
    data = d;
    wt = 0;
    @(negedge clock);
    while (gnt == '0 && wt < 40) begin
      @(negedge clock);
      wt++;
    end
    chk("midrst_gnt", gnt, 4'b0100);
    @(posedge clock); #1;
    req = '0;
    repeat (5) @(posedge clock);
    #1;
    reset = 1'b1;
    #2;
    chk("midrst_gnt0", gnt, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_valid", res_valid, 0);
    chk("midrst_id", res_id, 0);
    chk("midrst_count", res_count, 0);
    @(posedge clock); #1;
    req   = 4'b1111;
    reset = 1'b0;
    mptr  = 0;
    @(negedge clock);
    chk("gnt_after_rst", gnt, 0);
    chk("valid_after_rst", res_valid, 0);
    @(posedge clock); #1;

    // All requesters held: grants rotate 0,1,2,3,0.
    for (int i = 0; i < 5; i++) begin
      d = rand_data();
      txn($sformatf("fair%0d", i), 4'b1111, d, 0, i % N, $countones(d[(i % N)*W +: W]));
    end

    for (int i = 0; i < 40; i++) begin
      d  = rand_data();
      if (i % 5 == 0) d[($urandom % N)*W +: W] = W'($urandom_range(0, 7));
      r  = N'($urandom_range(1, (1 << N) - 1));
      gi = model_pick(r);
      txn($sformatf("rnd%0d", i), r, d, $urandom_range(0, 3), gi, $countones(d[gi*W +: W]));
    end
    req = '0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ones_count_arbiter.md
ONES_COUNT_ARBITER -- requirements
Module: ones_count_arbiter

Interface
REQ-001 Parameter W, 30, data word width (W >= 2).
REQ-002 Parameter N, 4, number of requesters (N >= 2).
REQ-003 clock  input  1  clock; all state updates on posedge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 req  input  N  req[i] = requester i has a word pending; held high until granted.
REQ-006 data  input  N*W  word of requester i on data[i*W +: W]; stable while req[i] is high.
REQ-007 gnt  output  N  one-hot grant pulse, one cycle; data[i] is captured in that cycle.
REQ-008 busy  output  1  high from the cycle after a grant until the result handshake completes.
REQ-009 res_valid  output  1  result available; held until accepted.
REQ-010 res_ready  input  1  consumer accepts the result when res_valid and res_ready are both high.
REQ-011 res_id  output  $clog2(N)  index of the requester the result belongs to.
REQ-012 res_count  output  $clog2(W+1)  number of ones in the granted word (0..W inclusive).

Function
REQ-013 FSM states IDLE, COUNT, DONE; no other reachable states.
REQ-014 IDLE: if any req bit is high, grant the first requester at or after the round-robin pointer (wrapping past N-1 to 0), load its word into the shift register, clear the bit and ones counters, latch its index, go to COUNT; otherwise stay in IDLE with gnt = 0.
REQ-015 COUNT: each cycle shift right by 1, increment the ones counter if the pre-shift bit 0 is 1, increment the bit counter; after the W-th shift go to DONE.
REQ-016 DONE: res_valid = 1, res_count and res_id stable; on res_valid & res_ready go to IDLE and set the pointer to (res_id + 1) mod N.
REQ-017 Latency: grant in cycle t -> res_valid first high in cycle t+W+1 (without early exit).
REQ-018 gnt is asserted only in IDLE, at most one bit high, and never in the cycle a result is accepted; the next grant is one cycle after acceptance at the earliest.
REQ-019 Requests arriving during COUNT/DONE wait; req deassertion before grant withdraws the request without error.
REQ-020 Fairness: with all N requests held continuously, grants cycle i, i+1, ..., with no requester granted twice before every other requester has been granted once.
REQ-021 Counters size to $clog2(W+1); an all-ones word yields res_count = W without overflow.
REQ-022 res_ready high while res_valid is low has no effect.

Reset
REQ-023 Reset forces IDLE, pointer = 0, gnt = 0, busy = 0, res_valid = 0, res_id = 0, res_count = 0.
REQ-024 Reset during COUNT or DONE discards the in-flight word; no result is produced for it and no grant is asserted in the first cycle after reset release.

Configuration
REQ-025 Macro ONES_COUNT_ARB_EARLY_EXIT_EN defined: COUNT goes to DONE in the cycle after the shift register becomes all-zero (an all-zero word loaded goes to DONE after 1 COUNT cycle); res_count is identical to the full scan.
REQ-026 Macro undefined: COUNT always lasts exactly W cycles regardless of data.

Structure
REQ-027 Shared package holds the state enum type (IDLE, COUNT, DONE) and width helper constants for count and id widths.
REQ-028 One sub-module popcount_engine (shift register, bit counter, ones counter, done flag) with load/shift controls from the arbiter FSM; arbitration and handshake stay in ones_count_arbiter.

Verification (W = 30, N = 4)
REQ-029 Reset, req = 4'b0100, data[2] = 30'h3FFFFFFF -> gnt = 4'b0100 in the next cycle, res_valid W+1 cycles after the grant with res_id = 2 and res_count = 30.
REQ-030 req = 4'b1111 held, res_ready = 1 -> grant order 0, 1, 2, 3, 0; each res_id matches its grant.
REQ-031 Single word 30'h00000005, res_ready = 0 for 5 cycles after res_valid -> res_valid and res_count = 2 held, no new grant, then acceptance returns to IDLE.
REQ-032 Reset pulsed mid-COUNT -> all outputs 0 next cycle, no res_valid for the discarded word, next request granted normally.
REQ-033 ONES_COUNT_ARB_EARLY_EXIT_EN defined, word 30'h00000001 -> res_count = 1, res_valid 2 cycles after the grant; word 0 -> res_count = 0, res_valid 2 cycles after the grant.
